// File: rtl/tsp_pkg.sv
// tsp_pkg: shared state codes, status patterns and default widths
// for the TSP board-level run sequencer.
package tsp_pkg;

   localparam int N_CITY_D = 8;
   localparam int CITY_W_D = 3;
   localparam int COST_W_D = 16;

   localparam logic [COST_W_D-1:0] COST_NONE = '1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LAUNCH = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_SHOW   = 3'd3;
   localparam logic [2:0] ST_ERR    = 3'd4;

   localparam logic [3:0] STAT_IDLE   = 4'b0001;
   localparam logic [3:0] STAT_LAUNCH = 4'b0010;
   localparam logic [3:0] STAT_RUN    = 4'b0100;
   localparam logic [3:0] STAT_SHOW   = 4'b1000;
   localparam logic [3:0] STAT_ERR    = 4'b1111;

   function automatic logic [3:0] state_status(input logic [2:0] st);
      logic [3:0] s;
      s = STAT_IDLE;
      unique case (st)
         ST_IDLE:   s = STAT_IDLE;
         ST_LAUNCH: s = STAT_LAUNCH;
         ST_RUN:    s = STAT_RUN;
         ST_SHOW:   s = STAT_SHOW;
         ST_ERR:    s = STAT_ERR;
         default:   s = STAT_IDLE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/tsp_tick_gen.sv
// tsp_tick_gen: free-running divider, one-cycle tick every TICK_DIV
// clocks; shared by the display blocks.
module tsp_tick_gen
   import tsp_pkg::*;
#(
   parameter int TICK_DIV = 50000000
) (
   input  logic CLOCK_50,
   input  logic nrst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge CLOCK_50 or negedge nrst) begin
      if (!nrst) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/tsp_run_sequencer.sv
// tsp_run_sequencer: switch-driven launch, timeout supervision and display
// sequencing for the TSP core. Define TSP_CYCLE_COUNT_EN to add run_cycles.
module tsp_run_sequencer
   import tsp_pkg::*;
#(
   parameter int N_CITY   = N_CITY_D,
   parameter int CITY_W   = CITY_W_D,
   parameter int COST_W   = COST_W_D,
   parameter int TICK_DIV = 50000000,
   parameter int TIMEOUT  = 16777216
) (
   input  logic                     CLOCK_50,
   input  logic                     nrst,
   input  logic                     start_sw,
   input  logic                     mode_sw,
   output logic                     core_start,
   input  logic                     core_busy,
   input  logic                     core_done,
   input  logic [COST_W-1:0]        core_cost,
   input  logic [N_CITY*CITY_W-1:0] core_route,
   output logic [COST_W-1:0]        best_cost,
   output logic                     disp_sel,
   output logic [CITY_W-1:0]        disp_idx,
   output logic [CITY_W-1:0]        disp_city,
`ifdef TSP_CYCLE_COUNT_EN
   output logic [31:0]              run_cycles,
`endif
   output logic [3:0]               status
);

   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [CITY_W-1:0] IDX_LAST = CITY_W'(N_CITY - 1);

   logic [2:0]        start_q;
   logic [1:0]        mode_q;
   logic [2:0]        sync_vld;
   logic              start_edge;
   logic              tick;
   logic [2:0]        state;
   logic [2:0]        state_nx;
   logic [TW-1:0]     timer;
   logic [CITY_W-1:0] route_q [N_CITY];

   tsp_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .CLOCK_50 (CLOCK_50),
      .nrst     (nrst),
      .tick     (tick)
   );

   always_ff @(posedge CLOCK_50 or negedge nrst) begin
      if (!nrst) begin
         start_q  <= '0;
         mode_q   <= '0;
         sync_vld <= '0;
      end else begin
         start_q  <= {start_q[1:0], start_sw};
         mode_q   <= {mode_q[0], mode_sw};
         sync_vld <= {sync_vld[1:0], 1'b1};
      end
   end

   // The delayed copy only holds a real sample once the chain has filled;
   // before that a switch held through reset would look like a fresh edge.
   assign start_edge = start_q[1] & ~start_q[2] & sync_vld[2];

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE, ST_SHOW, ST_ERR: begin
            if (start_edge && !core_busy) state_nx = ST_LAUNCH;
         end
         ST_LAUNCH: state_nx = ST_RUN;
         ST_RUN: begin
            if (core_done)             state_nx = ST_SHOW;
            else if (timer == TMO_LAST) state_nx = ST_ERR;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge nrst) begin
      if (!nrst) state <= ST_IDLE;
      else       state <= state_nx;
   end

   assign disp_sel = (state == ST_SHOW) & mode_q[1];

   always_ff @(posedge CLOCK_50 or negedge nrst) begin
      if (!nrst) begin
         timer     <= '0;
         best_cost <= '1;
         disp_idx  <= '0;
         for (int k = 0; k < N_CITY; k++) route_q[k] <= '0;
      end else begin
         unique case (state)
            ST_LAUNCH: timer <= '0;
            ST_RUN: begin
               timer <= timer + 1'b1;
               if (core_done) begin
                  best_cost <= core_cost;
                  disp_idx  <= '0;
                  for (int k = 0; k < N_CITY; k++)
                     route_q[k] <= core_route[k*CITY_W +: CITY_W];
               end
            end
            ST_SHOW: begin
               if (disp_sel && tick)
                  disp_idx <= (disp_idx == IDX_LAST) ? '0 : disp_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef TSP_CYCLE_COUNT_EN
   always_ff @(posedge CLOCK_50 or negedge nrst) begin
      if (!nrst)
         run_cycles <= '0;
      else if (state == ST_RUN && core_done)
         run_cycles <= 32'(timer) + 32'd1;
   end
`endif

   assign disp_city  = route_q[disp_idx];
   assign core_start = (state == ST_LAUNCH);
   assign status     = state_status(state);

endmodule

// File: tb/tb_tsp_run_sequencer.sv
// tb_tsp_run_sequencer: directed and randomized stimulus against a
// behavioural model of the run sequencer.
module tb_tsp_run_sequencer;

   localparam int N_CITY   = 8;
   localparam int CITY_W   = 3;
   localparam int COST_W   = 16;
   localparam int TICK_DIV = 4;
   localparam int TIMEOUT  = 64;

   localparam int M_IDLE   = 0;
   localparam int M_LAUNCH = 1;
   localparam int M_RUN    = 2;
   localparam int M_SHOW   = 3;
   localparam int M_ERR    = 4;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic start_sw = 1'b0;
   logic mode_sw = 1'b0;
   logic core_busy = 1'b0;
   logic core_done = 1'b0;
   logic [COST_W-1:0] core_cost = '0;
   logic [N_CITY*CITY_W-1:0] core_route = '0;
   logic core_start;
   logic [COST_W-1:0] best_cost;
   logic disp_sel;
   logic [CITY_W-1:0] disp_idx;
   logic [CITY_W-1:0] disp_city;
   logic [3:0] status;
`ifdef TSP_CYCLE_COUNT_EN
   logic [31:0] run_cycles;
`endif

   tsp_run_sequencer #(
      .N_CITY   (N_CITY),
      .CITY_W   (CITY_W),
      .COST_W   (COST_W),
      .TICK_DIV (TICK_DIV),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .CLOCK_50   (clk),
      .nrst       (nrst),
      .start_sw   (start_sw),
      .mode_sw    (mode_sw),
      .core_start (core_start),
      .core_busy  (core_busy),
      .core_done  (core_done),
      .core_cost  (core_cost),
      .core_route (core_route),
      .best_cost  (best_cost),
      .disp_sel   (disp_sel),
      .disp_idx   (disp_idx),
      .disp_city  (disp_city),
`ifdef TSP_CYCLE_COUNT_EN
      .run_cycles (run_cycles),
`endif
      .status     (status)
   );

   always #10 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // model state
   int m_st;
   int m_timer;
   int m_tc;
   int m_idx;
   int m_runc;
   logic [COST_W-1:0] m_best;
   int m_route [N_CITY];
   bit samp [$];
   bit msamp [$];

   function automatic logic [3:0] m_status(input int st);
      case (st)
         M_LAUNCH: return 4'b0010;
         M_RUN:    return 4'b0100;
         M_SHOW:   return 4'b1000;
         M_ERR:    return 4'b1111;
         default:  return 4'b0001;
      endcase
   endfunction

   // switch value as seen two samples ago, and the one before that
   function automatic bit m_edge();
      int c = samp.size();
      return c >= 3 && samp[c-2] && !samp[c-3];
   endfunction

   function automatic bit m_sel();
      int c = msamp.size();
      return m_st == M_SHOW && c >= 2 && msamp[c-2];
   endfunction

   task automatic model_reset();
      m_st = M_IDLE;
      m_timer = 0;
      m_tc = 0;
      m_idx = 0;
      m_runc = 0;
      m_best = '1;
      for (int k = 0; k < N_CITY; k++) m_route[k] = 0;
      samp.delete();
      msamp.delete();
   endtask

   task automatic model_step();
      bit e;
      bit sel;
      bit tick;
      e = m_edge();
      sel = m_sel();
      tick = (m_tc == TICK_DIV - 1);
      if (sel && tick) m_idx = (m_idx + 1) % N_CITY;
      case (m_st)
         M_IDLE, M_SHOW, M_ERR: if (e && !core_busy) m_st = M_LAUNCH;
         M_LAUNCH: begin
            m_timer = 0;
            m_st = M_RUN;
         end
         M_RUN: begin
            if (core_done) begin
               m_best = core_cost;
               for (int k = 0; k < N_CITY; k++)
                  m_route[k] = int'(core_route[k*CITY_W +: CITY_W]);
               m_idx = 0;
               m_runc = m_timer + 1;
               m_st = M_SHOW;
            end else if (m_timer == TIMEOUT - 1) begin
               m_st = M_ERR;
            end else begin
               m_timer++;
            end
         end
         default: m_st = M_IDLE;
      endcase
      m_tc = (m_tc + 1) % TICK_DIV;
      samp.push_back(start_sw);
      msamp.push_back(mode_sw);
      if (samp.size() > 4) void'(samp.pop_front());
      if (msamp.size() > 4) void'(msamp.pop_front());
   endtask

   task automatic check_outputs();
      chk("status", 32'(status), 32'(m_status(m_st)));
      chk("core_start", 32'(core_start), 32'(m_st == M_LAUNCH));
      chk("best_cost", 32'(best_cost), 32'(m_best));
      chk("disp_sel", 32'(disp_sel), 32'(m_sel()));
      chk("disp_idx", 32'(disp_idx), 32'(m_idx));
      chk("disp_city", 32'(disp_city), 32'(m_route[m_idx]));
`ifdef TSP_CYCLE_COUNT_EN
      chk("run_cycles", run_cycles, 32'(m_runc));
`endif
   endtask

   task automatic cyc();
      @(posedge clk);
      if (nrst) model_step();
      else model_reset();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic assert_reset();
      nrst = 1'b0;
      model_reset();
      #1;
      check_outputs();
   endtask

   task automatic press();
      start_sw = 1'b0;
      repeat (3) cyc();
      start_sw = 1'b1;
   endtask

   task automatic wait_run(input int lim);
      for (int i = 0; i < lim && m_st != M_RUN; i++) cyc();
      if (m_st != M_RUN) chk("wait_run", 32'(status), 32'(4'b0100));
   endtask

   function automatic logic [N_CITY*CITY_W-1:0] pack_route(input int r [N_CITY]);
      logic [N_CITY*CITY_W-1:0] v;
      v = '0;
      for (int k = 0; k < N_CITY; k++) v[k*CITY_W +: CITY_W] = CITY_W'(r[k]);
      return v;
   endfunction

   initial begin
      int k;
      int r [N_CITY];
      r = '{0, 3, 1, 7, 2, 5, 4, 6};

      // reset held with the switch already up
      start_sw = 1'b1;
      @(negedge clk);
      assert_reset();
      repeat (5) cyc();
      nrst = 1'b1;
      repeat (10) cyc();
      chk("no_launch_after_rst", 32'(status), 32'(4'b0001));

      // first launch and its latency
      start_sw = 1'b0;
      repeat (3) cyc();
      start_sw = 1'b1;
      k = 0;
      while (core_start !== 1'b1 && k < 10) begin
         cyc();
         k++;
      end
      chk("launch_latency", 32'(k), 32'd3);
      cyc();
      chk("run_after_launch", 32'(status), 32'(4'b0100));

      // done 10 cycles into RUN
      repeat (10) cyc();
      core_cost = 16'd1234;
      core_route = pack_route(r);
      core_done = 1'b1;
      cyc();
      core_done = 1'b0;
      chk("done_best", 32'(best_cost), 32'd1234);
      chk("done_status", 32'(status), 32'(4'b1000));
`ifdef TSP_CYCLE_COUNT_EN
      chk("done_run_cycles", run_cycles, 32'd11);
`endif
      mode_sw = 1'b1;
      repeat (40) cyc();
      mode_sw = 1'b0;
      repeat (6) cyc();

      // timeout keeps the old cost
      press();
      wait_run(10);
      repeat (70) cyc();
      chk("timeout_status", 32'(status), 32'(4'b1111));
      chk("timeout_best", 32'(best_cost), 32'd1234);
      chk("timeout_sel", 32'(disp_sel), 32'd0);

      // done on the last RUN cycle beats the timeout
      press();
      wait_run(10);
      while (m_st == M_RUN && m_timer < TIMEOUT - 1) cyc();
      core_cost = 16'd999;
      core_route = pack_route('{7, 6, 5, 4, 3, 2, 1, 0});
      core_done = 1'b1;
      cyc();
      core_done = 1'b0;
      chk("collide_status", 32'(status), 32'(4'b1000));
      chk("collide_best", 32'(best_cost), 32'd999);

      // busy core blocks a launch from SHOW
      core_busy = 1'b1;
      press();
      repeat (6) cyc();
      chk("busy_lockout", 32'(status), 32'(4'b1000));
      core_busy = 1'b0;
      repeat (4) cyc();

      // edges during RUN are ignored
      press();
      wait_run(10);
      press();
      repeat (4) cyc();
      chk("run_lockout", 32'(status), 32'(4'b0100));

      // reset mid-run
      assert_reset();
      chk("midrun_rst", 32'(status), 32'(4'b0001));
      repeat (2) cyc();
      nrst = 1'b1;
      repeat (8) cyc();
      chk("post_rst_idle", 32'(status), 32'(4'b0001));
      chk("post_rst_best", 32'(best_cost), 32'hFFFF);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 11) == 0) start_sw = ~start_sw;
         if ($urandom_range(0, 19) == 0) mode_sw = ~mode_sw;
         core_busy = ($urandom_range(0, 3) == 0);
         core_cost = COST_W'($urandom);
         core_route = (N_CITY*CITY_W)'($urandom);
         core_done = (m_st == M_RUN) ? ($urandom_range(0, 47) == 0)
                                     : ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 799) == 0) begin
            core_done = 1'b0;
            assert_reset();
            repeat (2) cyc();
            nrst = 1'b1;
         end
         cyc();
      end
      core_done = 1'b0;
      repeat (4) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
